// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
// Also holds the opcode-to-class decode used by both dispatch and output decode.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LUI    = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_JALR   = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_BRANCH = 4'd8,
    CLS_BAD    = 4'd9
  } instr_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic instr_class_e decode_class(input logic [6:0] opcode);
    instr_class_e cls;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch resolution from funct3 and the ALU zero flag of the compare.
// BLT/BLTU/BGE/BGEU rely on the compare leaving zero=1 when the "less" result is 0.
module branch_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken,
  output logic       bad_funct3
);

  // Combinational taken/illegal decode per branch flavour
  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:         taken = zero;
      3'b001:         taken = !zero;
      3'b100, 3'b110: taken = !zero;
      3'b101, 3'b111: taken = zero;
      default:        bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a timed req/ack memory handshake.
// Strobes are decoded from the state register so reset drops them immediately and ir_we can follow mem_ack.
module multicycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        illegal,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic         illegal_r;
  logic         bus_err_r;
  instr_class_e class_s;
  logic         taken_s;
  logic         bad_funct3_s;
  logic         timeout_s;
  logic         is_store_s;
  logic         unused_bits_s;

  assign class_s       = decode_class(instruction[6:0]);
  assign is_store_s    = (class_s == CLS_STORE);
  assign timeout_s     = mem_req && !mem_ack && (cnt_r == CNT_W'(ACK_TIMEOUT - 1));
  assign unused_bits_s = ^{instruction[31:15], instruction[11:7]};

  branch_eval u_branch_eval (
    .funct3     (instruction[14:12]),
    .zero       (zero),
    .taken      (taken_s),
    .bad_funct3 (bad_funct3_s)
  );

  // State transitions, sticky trap flags and handshake wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ack) begin
            state_r <= ST_DECODE;
          end else if (timeout_s) begin
            state_r   <= ST_TRAP;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (class_s == CLS_BAD) begin
            state_r   <= ST_TRAP;
            illegal_r <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (class_s)
            CLS_LOAD, CLS_STORE: state_r <= ST_MEM;
            CLS_BRANCH: begin
              if (bad_funct3_s) begin
                state_r   <= ST_TRAP;
                illegal_r <= 1'b1;
              end else begin
                state_r <= ST_FETCH;
              end
            end
            CLS_BAD: begin
              state_r   <= ST_TRAP;
              illegal_r <= 1'b1;
            end
            default: state_r <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            state_r <= is_store_s ? ST_FETCH : ST_WB;
          end else if (timeout_s) begin
            state_r   <= ST_TRAP;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB:   state_r <= ST_FETCH;
        ST_TRAP: state_r <= ST_TRAP;
        default: state_r <= ST_TRAP;
      endcase

      // Any ack, the timeout, or a cycle without a request restarts the wait count
      if (mem_req && !mem_ack && !timeout_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Per-state datapath strobe decode
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    case (state_r)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      ST_EXEC: begin
        case (class_s)
          CLS_R: begin
            alu_op    = ALU_FUNCT;
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
          end
          CLS_I: begin
            alu_op    = ALU_FUNCT;
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
          end
          CLS_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
          end
          CLS_AUIPC, CLS_JAL: begin
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_IMM;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
          end
          CLS_BRANCH: begin
            alu_op    = ALU_CMP;
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            pc_we     = !bad_funct3_s;
            pc_sel    = (taken_s && !bad_funct3_s) ? PC_TARGET : PC_PLUS4;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store_s;
        pc_we   = mem_ack && is_store_s;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        case (class_s)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_TARGET;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign state_o = state_r;
  assign illegal = illegal_r;
  assign bus_err = bus_err_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: a table of instructions run with zero-wait memory, then hand sequences
// for wait states, handshake timeout, illegal traps and reset during a store.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, illegal, bus_err;
  logic [1:0]  pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0]  state_o;

  int total;
  int bad;

  multicycle_sequencer #(.ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .state_o     (state_o),
    .illegal     (illegal),
    .bus_err     (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        z;
    logic [1:0]  ex_op;
    logic [1:0]  ex_a;
    logic [1:0]  ex_b;
    logic        ex_pcwe;
    logic [1:0]  ex_pcsel;
    logic [2:0]  after_ex;
    logic        store;
    logic [1:0]  wb_sel;
    logic [1:0]  wb_pcsel;
    int          lat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, logic [31:0] i, logic z, logic [1:0] op, logic [1:0] a,
                              logic [1:0] b, logic pw, logic [1:0] ps, logic [2:0] nx, logic st,
                              logic [1:0] ws, logic [1:0] wps, int lat);
    vec_t v;
    v.name = n; v.instr = i; v.z = z; v.ex_op = op; v.ex_a = a; v.ex_b = b;
    v.ex_pcwe = pw; v.ex_pcsel = ps; v.after_ex = nx; v.store = st;
    v.wb_sel = ws; v.wb_pcsel = wps; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int lat;
    int n;
    logic any_strobe;
    total = 0;
    bad = 0;
    rst = 1'b0;
    instruction = 32'h002081B3;
    zero = 1'b0;
    mem_ack = 1'b1;
    #12;
    chk("reset_state", {29'd0, state_o}, 32'd0);
    chk("reset_strobes", {22'd0, mem_req, mem_we, ir_we, pc_we, reg_we, illegal, bus_err, pc_sel, wb_sel},
        32'd0);

    //         name       instr         z  op     a      b      pw  ps     next   st  wb     wbps   lat
    vq.push_back(mk("add",   32'h002081B3, 0, 2'b10, 2'b01, 2'b00, 0, 2'b00, 3'd5, 0, 2'b00, 2'b00, 4));
    vq.push_back(mk("addi",  32'h00500093, 0, 2'b10, 2'b01, 2'b01, 0, 2'b00, 3'd5, 0, 2'b00, 2'b00, 4));
    vq.push_back(mk("lui",   32'h123452B7, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 3'd5, 0, 2'b00, 2'b00, 4));
    vq.push_back(mk("auipc", 32'h00001297, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 3'd5, 0, 2'b00, 2'b00, 4));
    vq.push_back(mk("jal",   32'h008000EF, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 3'd5, 0, 2'b10, 2'b01, 4));
    vq.push_back(mk("jalr",  32'h000100E7, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 3'd5, 0, 2'b10, 2'b10, 4));
    vq.push_back(mk("lw",    32'h0000A183, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 3'd4, 0, 2'b01, 2'b00, 5));
    vq.push_back(mk("sw",    32'h0020A023, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 3'd4, 1, 2'b00, 2'b00, 4));
    vq.push_back(mk("beq_t", 32'h00208463, 1, 2'b01, 2'b01, 2'b00, 1, 2'b01, 3'd1, 0, 2'b00, 2'b00, 3));
    vq.push_back(mk("beq_n", 32'h00208463, 0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 3'd1, 0, 2'b00, 2'b00, 3));
    vq.push_back(mk("bne_t", 32'h00209463, 0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 3'd1, 0, 2'b00, 2'b00, 3));
    vq.push_back(mk("bge_n", 32'h0020D463, 0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 3'd1, 0, 2'b00, 2'b00, 3));
    vq.push_back(mk("bltu_t",32'h0020E463, 0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 3'd1, 0, 2'b00, 2'b00, 3));

    foreach (vq[i]) begin
      instruction = vq[i].instr;
      zero = vq[i].z;
      mem_ack = 1'b1;
      do_reset();
      chk({vq[i].name, "_idle"}, {29'd0, state_o}, 32'd0);
      step();
      chk({vq[i].name, "_fetch"}, {28'd0, state_o, mem_req}, {28'd0, 3'd1, 1'b1});
      chk({vq[i].name, "_ir_we"}, {31'd0, ir_we}, 32'd1);
      step();
      chk({vq[i].name, "_decode"}, {26'd0, state_o, mem_req, pc_we, reg_we}, {26'd0, 3'd2, 3'b000});
      step();
      chk({vq[i].name, "_exec"}, {19'd0, state_o, alu_op, alu_src_a, alu_src_b, pc_we, pc_sel, reg_we},
          {19'd0, 3'd3, vq[i].ex_op, vq[i].ex_a, vq[i].ex_b, vq[i].ex_pcwe, vq[i].ex_pcsel, 1'b0});
      lat = 3;
      step();
      chk({vq[i].name, "_after_exec"}, {29'd0, state_o}, {29'd0, vq[i].after_ex});
      for (int k = 0; k < 4 && state_o != 3'd1; k++) begin
        lat++;
        if (state_o == 3'd4) begin
          chk({vq[i].name, "_mem"}, {28'd0, mem_req, mem_we, pc_we, reg_we},
              {28'd0, 1'b1, vq[i].store, vq[i].store, 1'b0});
        end else if (state_o == 3'd5) begin
          chk({vq[i].name, "_wb"}, {25'd0, reg_we, wb_sel, pc_we, pc_sel, mem_req},
              {25'd0, 1'b1, vq[i].wb_sel, 1'b1, vq[i].wb_pcsel, 1'b0});
        end else begin
          chk({vq[i].name, "_state"}, {29'd0, state_o}, 32'd5);
        end
        step();
      end
      chk({vq[i].name, "_latency"}, lat, vq[i].lat);
      chk({vq[i].name, "_refetch"}, {29'd0, state_o}, 32'd1);
    end

    // Load with three wait states in MEM
    instruction = 32'h0000A183;
    mem_ack = 1'b1;
    do_reset();
    step(); step(); step();
    mem_ack = 1'b0;
    step();
    chk("lw_wait_mem", {29'd0, state_o}, 32'd4);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_req) n++;
      step();
    end
    mem_ack = 1'b1;
    #1;
    if (mem_req) n++;
    chk("lw_wait_req_cycles", n, 4);
    chk("lw_wait_still_mem", {29'd0, state_o}, 32'd4);
    step();
    chk("lw_wait_wb", {28'd0, state_o, reg_we, wb_sel}, {28'd0, 3'd5, 1'b1, 2'b01});

    // Fetch handshake timeout
    instruction = 32'h002081B3;
    mem_ack = 1'b0;
    do_reset();
    step();
    n = 0;
    while (state_o == 3'd1 && n < 40) begin
      n++;
      step();
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_trap", {27'd0, state_o, bus_err, mem_req}, {27'd0, 3'd6, 1'b1, 1'b0});
    chk("timeout_no_illegal", {31'd0, illegal}, 32'd0);

    // Ack on the last allowed cycle beats the timeout
    do_reset();
    step();
    for (int k = 0; k < 15; k++) step();
    mem_ack = 1'b1;
    #1;
    chk("late_ack_ir_we", {31'd0, ir_we}, 32'd1);
    step();
    chk("late_ack_decode", {28'd0, state_o, bus_err}, {28'd0, 3'd2, 1'b0});

    // Unknown opcode traps in DECODE and stays quiet until reset
    instruction = 32'hFFFFFFFF;
    mem_ack = 1'b1;
    do_reset();
    step(); step(); step();
    chk("illegal_trap", {28'd0, state_o, illegal}, {28'd0, 3'd6, 1'b1});
    any_strobe = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      any_strobe = any_strobe | mem_req | mem_we | ir_we | pc_we | reg_we | (state_o != 3'd6);
    end
    chk("illegal_quiet", {31'd0, any_strobe}, 32'd0);
    rst = 1'b0;
    #1;
    chk("illegal_cleared", {28'd0, state_o, illegal}, 32'd0);
    #1;
    rst = 1'b1;

    // Reserved branch funct3 traps in EXEC without touching the PC
    instruction = 32'h0020A463;
    do_reset();
    step(); step(); step();
    chk("bad_funct3_exec_pc_we", {31'd0, pc_we}, 32'd0);
    step();
    chk("bad_funct3_trap", {28'd0, state_o, illegal}, {28'd0, 3'd6, 1'b1});

    // Reset asserted mid-MEM of a store drops the request immediately
    instruction = 32'h0020A023;
    mem_ack = 1'b1;
    do_reset();
    step(); step(); step();
    mem_ack = 1'b0;
    step();
    chk("store_in_mem", {27'd0, state_o, mem_req, mem_we}, {27'd0, 3'd4, 1'b1, 1'b1});
    rst = 1'b0;
    #1;
    chk("store_reset_drop", {27'd0, state_o, mem_req, mem_we}, 32'd0);
    rst = 1'b1;
    #1;
    chk("store_reset_idle", {29'd0, state_o}, 32'd0);
    step();
    chk("store_reset_fetch", {29'd0, state_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
